// File: rtl/cla_pkg.sv
// Shared constants and helpers for the CLA scheduler slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cla_pkg;

    localparam int DW      = 32;  // adder datapath width
    localparam int CLA_LAT = 2;   // m_cla_clk: input register + output register

    // One-hot (up to 8 ways) to binary index. An all-zero input yields 0.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) r = r | 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/m_cla_clk.sv
// Registered 32-bit carry-lookahead adder: input register, 4-bit lookahead groups, output register.
// Latency: 2 clocks from operands to sum/co.
// Backpressure: none; it accepts operands every clock.
// Ports: clock; a/b/ci operands; sum/co result. The registers have no reset and consumers mask invalid cycles.
module m_cla_clk
    import cla_pkg::*;
(
    input  logic          clock,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          ci,
    output logic [DW-1:0] sum,
    output logic          co
);

    logic [DW-1:0] a_q, b_q, sum_d, sum_q;
    logic          ci_q, co_d, co_q;

    always_ff @(posedge clock) begin
        a_q   <= a;
        b_q   <= b;
        ci_q  <= ci;
        sum_q <= sum_d;
        co_q  <= co_d;
    end

    // Lookahead within each 4-bit group; group carries chain across groups.
    always_comb begin : cla_core
        logic [DW-1:0] g, p;
        logic [DW:0]   c;
        int            b0;
        g    = a_q & b_q;
        p    = a_q ^ b_q;
        c    = '0;
        c[0] = ci_q;
        for (int gi = 0; gi < DW / 4; gi++) begin
            b0 = 4 * gi;
            c[b0+1] = g[b0] | (p[b0] & c[b0]);
            c[b0+2] = g[b0+1] | (p[b0+1] & g[b0]) | (p[b0+1] & p[b0] & c[b0]);
            c[b0+3] = g[b0+2] | (p[b0+2] & g[b0+1]) | (p[b0+2] & p[b0+1] & g[b0])
                    | (p[b0+2] & p[b0+1] & p[b0] & c[b0]);
            c[b0+4] = g[b0+3] | (p[b0+3] & g[b0+2]) | (p[b0+3] & p[b0+2] & g[b0+1])
                    | (p[b0+3] & p[b0+2] & p[b0+1] & g[b0])
                    | (p[b0+3] & p[b0+2] & p[b0+1] & p[b0] & c[b0]);
        end
        sum_d = p ^ c[DW-1:0];
        co_d  = c[DW];
    end

    assign sum = sum_q;
    assign co  = co_q;

endmodule

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first asserted request at or above ptr, wrapping modulo NREQ.
// Latency: combinational.
// Backpressure: none; the caller masks the grant when it cannot issue.
// Ports: req (request vector), ptr (highest-priority slot); grant (one-hot, 0 if no request), idx (binary winner).
module rr_arbiter
    import cla_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx
);

    always_comb begin : search
        int   j;
        logic found;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin : encode
        logic [7:0] oh8;
        oh8             = '0;
        oh8[NREQ-1:0]   = grant;
        idx             = PW'(onehot_to_idx(oh8));
    end

endmodule

// File: rtl/cla_rr_sched.sv
// Round-robin scheduler sharing one registered CLA adder among NREQ requesters.
// Latency: an op accepted in cycle t returns its rsp_valid/rsp_sum/rsp_co in cycle t+2.
// Backpressure: one grant per clock via req_ready (gated by issue_en); responses cannot be stalled.
// Ports: clock, reset (sync, active-high), issue_en; req_valid/req_a/req_b/req_ci in, req_ready out;
//        rsp_valid (one-hot), rsp_sum, rsp_co; inflight (ops in the adder), idle.
module cla_rr_sched
    import cla_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = CLA_LAT,  // tied to m_cla_clk's two register stages
    parameter int CW   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_en,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ-1:0]  req_ci,
    output logic [NREQ-1:0]  req_ready,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [DW-1:0]    rsp_sum,
    output logic             rsp_co,
    output logic [CW-1:0]    inflight,
    output logic             idle
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   win_idx;
    logic            transfer;
    logic            retire;
    logic [NREQ-1:0] tag [LAT];
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   add_a, add_b, add_sum;
    logic            add_ci, add_co;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    // Grant only exists when some request is valid, so any ready bit means a transfer.
    assign req_ready = grant & {NREQ{issue_en & ~reset}};
    assign transfer  = |req_ready;
    assign retire    = |tag[LAT-1];

    // Idle cycles feed zeros so the adder never sees stale operands.
    assign add_a  = transfer ? req_a[DW*win_idx +: DW] : '0;
    assign add_b  = transfer ? req_b[DW*win_idx +: DW] : '0;
    assign add_ci = transfer ? req_ci[win_idx]         : 1'b0;

    m_cla_clk u_add (
        .clock (clock),
        .a     (add_a),
        .b     (add_b),
        .ci    (add_ci),
        .sum   (add_sum),
        .co    (add_co)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
        end
    end

    // Tag pipe mirrors the adder stages; clearing it on reset drops in-flight results.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) tag[k] <= '0;
        end else begin
            tag[0] <= req_ready & req_valid;
            for (int k = 1; k < LAT; k++) tag[k] <= tag[k-1];
        end
    end

    // Net change covers issue and retire in the same cycle; equals popcount of non-empty tag stages.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(transfer) - CW'(retire);
        end
    end

    assign rsp_valid = tag[LAT-1];
    assign rsp_sum   = add_sum & {DW{retire}};
    assign rsp_co    = add_co & retire;
    assign inflight  = cnt;
    assign idle      = (cnt == '0) & ~transfer;

endmodule
